// File: rtl/rd53_pkg.sv
// Shared constants for the RD53 TTC receive path: default sync word and
// frame-aligner state encoding.
package rd53_pkg;

  localparam logic [15:0] TTC_SYNC_PATTERN = 16'h817E;

  localparam logic [1:0] ST_SEARCH    = 2'd0;
  localparam logic [1:0] ST_CANDIDATE = 2'd1;
  localparam logic [1:0] ST_LOCKED    = 2'd2;

endpackage

// File: rtl/ttc_bit_shifter.sv
// Serial-to-parallel front end: 16-bit MSB-first shift register plus a
// free-running mod-16 bit counter used as the frame-phase reference.
module ttc_bit_shifter (
  input  logic        clk160,
  input  logic        rst,
  input  logic        ttc_data,
  output logic [15:0] sr,
  output logic [3:0]  bit_cnt
);

  always_ff @(posedge clk160 or posedge rst) begin
    if (rst) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else begin
      sr      <= {sr[14:0], ttc_data};
      bit_cnt <= bit_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/ttc_frame_aligner.sv
// TTC frame aligner: finds the sync word's bit phase, locks after
// LOCK_COUNT aligned syncs and emits every aligned non-sync frame.
module ttc_frame_aligner
  import rd53_pkg::*;
#(
  parameter logic [15:0] SYNC_PATTERN = TTC_SYNC_PATTERN,
  parameter int          LOCK_COUNT   = 32,
  parameter int          SYNC_TIMEOUT = 256
) (
  input  logic        clk160,
  input  logic        rst,
  input  logic        ttc_data,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        locked,
  output logic [3:0]  phase
);

  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int TO_W    = $clog2(SYNC_TIMEOUT + 1);

  localparam logic [MATCH_W-1:0] MATCH_ONE  = MATCH_W'(1);
  localparam logic [MATCH_W-1:0] MATCH_MAX  = MATCH_W'(LOCK_COUNT);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [TO_W-1:0]    TO_ONE     = TO_W'(1);
  localparam logic [TO_W-1:0]    TO_MAX     = TO_W'(SYNC_TIMEOUT);

  logic [15:0]        sr;
  logic [3:0]         bit_cnt;
  logic [1:0]         state;
  logic [MATCH_W-1:0] match_cnt;
  logic [TO_W-1:0]    timeout_cnt;
  logic               is_sync;
  logic               boundary;
  logic [TO_W-1:0]    timeout_next;

  ttc_bit_shifter u_shifter (
    .clk160   (clk160),
    .rst      (rst),
    .ttc_data (ttc_data),
    .sr       (sr),
    .bit_cnt  (bit_cnt)
  );

  assign is_sync      = (sr == SYNC_PATTERN);
  assign boundary     = (bit_cnt == phase);
  assign timeout_next = timeout_cnt + TO_ONE;

  always_ff @(posedge clk160 or posedge rst) begin
    if (rst) begin
      state       <= ST_SEARCH;
      phase       <= '0;
      match_cnt   <= '0;
      timeout_cnt <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      locked      <= 1'b0;
    end else begin
      // NOTE: default-then-override with non-blocking assignments; the last
      // assignment in program order wins, which makes data_valid a one-cycle strobe.
      data_valid <= 1'b0;
      case (state)
        ST_SEARCH: begin
          // Any bit offset is a candidate boundary while searching.
          if (is_sync) begin
            phase     <= bit_cnt;
            match_cnt <= MATCH_ONE;
            if (LOCK_COUNT <= 1) begin
              state       <= ST_LOCKED;
              locked      <= 1'b1;
              timeout_cnt <= '0;
            end else begin
              state <= ST_CANDIDATE;
            end
          end
        end

        ST_CANDIDATE: begin
          if (boundary) begin
            if (is_sync) begin
              if (match_cnt != MATCH_MAX) match_cnt <= match_cnt + MATCH_ONE;
              if (match_cnt >= MATCH_LAST) begin
                state       <= ST_LOCKED;
                locked      <= 1'b1;
                timeout_cnt <= '0;
              end
            end else begin
              state     <= ST_SEARCH;
              match_cnt <= '0;
            end
          end
        end

        ST_LOCKED: begin
          // Off-boundary bits, including stray sync patterns, are ignored.
          if (boundary) begin
            if (is_sync) begin
              timeout_cnt <= '0;
            end else if (timeout_next == TO_MAX) begin
              state       <= ST_SEARCH;
              locked      <= 1'b0;
              timeout_cnt <= '0;
              match_cnt   <= '0;
            end else begin
              timeout_cnt <= timeout_next;
              data_out    <= sr;
              data_valid  <= 1'b1;
            end
          end
        end

        default: begin
          state     <= ST_SEARCH;
          locked    <= 1'b0;
          match_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ttc_frame_aligner.sv
// Scoreboard bench for ttc_frame_aligner: a frame-walking reference model
// predicts strobes and lock transitions from the bit stream; a monitor compares.
module tb_ttc_frame_aligner;

  localparam logic [15:0] SYNC    = 16'h817E;
  localparam int          LOCK    = 32;
  localparam int          TIMEOUT = 256;
  localparam int          IDLE    = 15;

  typedef struct { int edge_no; logic [15:0] w; } dv_t;
  typedef struct { int edge_no; logic val; logic [3:0] ph; } lk_t;

  logic        clk160 = 1'b0;
  logic        rst = 1'b1;
  logic        ttc_data = 1'b0;
  logic [15:0] data_out;
  logic        data_valid;
  logic        locked;
  logic [3:0]  phase;

  int   n_checks = 0;
  int   n_fail = 0;
  int   edge_no;
  bit   mon_en = 1'b0;
  logic prev_locked = 1'b0;
  bit   stim[$];
  dv_t  exp_dv[$];
  lk_t  exp_lk[$];
  bit   model_locked_end;

  ttc_frame_aligner dut (
    .clk160     (clk160),
    .rst        (rst),
    .ttc_data   (ttc_data),
    .data_out   (data_out),
    .data_valid (data_valid),
    .locked     (locked),
    .phase      (phase)
  );

  always #5 clk160 = ~clk160;

  always @(posedge clk160 or posedge rst)
    if (rst) edge_no <= 0;
    else     edge_no <= edge_no + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes or changes lock.
  always @(negedge clk160) begin
    dv_t e;
    lk_t l;
    if (mon_en) begin
      if (data_valid) begin
        if (exp_dv.size() == 0) begin
          check("dv_unexpected", data_valid, 1'b0);
        end else begin
          e = exp_dv.pop_front();
          check("dv_edge", edge_no, e.edge_no);
          check("dv_word", data_out, e.w);
          check("dv_while_locked", locked, 1'b1);
        end
      end
      if (locked !== prev_locked) begin
        if (exp_lk.size() == 0) begin
          check("locked_unexpected", locked, prev_locked);
        end else begin
          l = exp_lk.pop_front();
          check("lock_edge", edge_no, l.edge_no);
          check("lock_value", locked, l.val);
          if (l.val) check("lock_phase", phase, l.ph);
        end
        prev_locked = locked;
      end
    end
  end

  task automatic add_word(input logic [15:0] w, input int n);
    for (int r = 0; r < n; r++)
      for (int i = 15; i >= 0; i--) stim.push_back(w[i]);
  endtask

  task automatic add_zeros(input int n);
    for (int i = 0; i < n; i++) stim.push_back(1'b0);
  endtask

  function automatic logic [15:0] rand_data();
    logic [15:0] w;
    do w = 16'($urandom); while (w == SYNC);
    return w;
  endfunction

  // Frame-level reference: bit k of the stream is shifted on edge k+1, so the
  // 16-bit window ending at bit j is judged on edge j+2 with counter (j+1)%16.
  task automatic build_model();
    int mode = 0;  // 0 searching, 1 qualifying, 2 locked
    int pos = 0;
    int cnt = 0;
    int to = 0;
    logic [15:0] w;
    exp_dv.delete();
    exp_lk.delete();
    for (int j = 15; j <= stim.size() - 2; j++) begin
      w = '0;
      for (int i = 0; i < 16; i++) w = {w[14:0], stim[j-15+i]};
      if (mode == 0) begin
        if (w == SYNC) begin
          pos = j % 16; cnt = 1; mode = 1;
        end
      end else if (j % 16 == pos) begin
        if (mode == 1) begin
          if (w == SYNC) begin
            cnt++;
            if (cnt >= LOCK) begin
              mode = 2; to = 0;
              exp_lk.push_back('{j + 2, 1'b1, 4'((j + 1) % 16)});
            end
          end else begin
            mode = 0; cnt = 0;
          end
        end else begin
          if (w == SYNC) to = 0;
          else if (to + 1 == TIMEOUT) begin
            mode = 0; to = 0; cnt = 0;
            exp_lk.push_back('{j + 2, 1'b0, 4'd0});
          end else begin
            to++;
            exp_dv.push_back('{j + 2, w});
          end
        end
      end
    end
    model_locked_end = (mode == 2);
  endtask

  task automatic do_reset();
    ttc_data = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk160);
    #2;
    rst = 1'b0;
  endtask

  task automatic run_stream(input string tag, input bit rst_mid);
    int n;
    n = stim.size();
    build_model();
    do_reset();
    prev_locked = 1'b0;
    mon_en = 1'b1;
    ttc_data = stim[0];
    for (int k = 0; k < n; k++) begin
      @(posedge clk160);
      #2;
      ttc_data = (k + 1 < n) ? stim[k+1] : 1'b0;
    end
    @(negedge clk160);
    #1;
    mon_en = 1'b0;
    check({tag, "_dv_drained"}, exp_dv.size(), 0);
    check({tag, "_lock_drained"}, exp_lk.size(), 0);
    check({tag, "_locked_end"}, locked, model_locked_end);
    if (rst_mid) begin
      rst = 1'b1;
      #1;
      check("async_rst_locked", locked, 1'b0);
      check("async_rst_dv", data_valid, 1'b0);
      check("async_rst_data_out", data_out, 16'h0000);
      check("async_rst_phase", phase, 4'd0);
      repeat (2) begin
        @(posedge clk160);
        #1;
        check("rst_hold_dv", data_valid, 1'b0);
      end
    end
    stim.delete();
  endtask

  initial begin
    rst = 1'b1;
    #12;
    check("reset_data_out", data_out, 16'h0000);
    check("reset_dv", data_valid, 1'b0);
    check("reset_locked", locked, 1'b0);
    check("reset_phase", phase, 4'd0);

    // Lock on 32nd sync, then incrementing payload words 16 cycles apart.
    add_zeros(IDLE);
    add_word(SYNC, 46);
    for (int i = 0; i < 12; i++) add_word(16'hAA6A + 16'(i), 1);
    run_stream("basic", 1'b0);

    // Broken qualification: a bad frame restarts the search.
    add_zeros(IDLE);
    add_word(SYNC, 20);
    add_word(16'h1234, 1);
    add_word(SYNC, 40);
    for (int i = 0; i < 4; i++) add_word(rand_data(), 1);
    run_stream("requal", 1'b0);

    // Timeout: 256 consecutive non-sync frames after lock.
    add_zeros(IDLE);
    add_word(SYNC, LOCK);
    for (int i = 0; i < TIMEOUT + 4; i++) add_word(rand_data(), 1);
    run_stream("timeout", 1'b0);

    // Stream slipped by 5 bits relative to the idle preamble.
    add_zeros(IDLE + 5);
    add_word(SYNC, 34);
    for (int i = 0; i < 6; i++) add_word(rand_data(), 1);
    run_stream("shift5", 1'b0);
    check("shift5_phase", phase, 4'd4);

    // Off-boundary sync patterns while locked must be passed through.
    add_zeros(IDLE);
    add_word(SYNC, 34);
    for (int i = 0; i < 20; i++) begin
      add_word(16'h5581, 1);
      add_word(16'h7E55, 1);
    end
    run_stream("embedded", 1'b0);

    // Asynchronous reset mid-frame while locked, then relock.
    add_zeros(IDLE);
    add_word(SYNC, 34);
    for (int i = 0; i < 3; i++) add_word(rand_data(), 1);
    add_word(16'hC3A5, 1);
    for (int i = 0; i < 9; i++) void'(stim.pop_back());
    run_stream("midrst", 1'b1);
    add_zeros(IDLE);
    add_word(SYNC, LOCK);
    for (int i = 0; i < 3; i++) add_word(rand_data(), 1);
    run_stream("relock", 1'b0);

    // Random mix of syncs, payload and occasional bit slips.
    add_zeros(IDLE);
    add_word(SYNC, 40);
    for (int i = 0; i < 100; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 7) add_word(rand_data(), 1);
      else if (r < 9) add_word(SYNC, 1);
      else for (int b = 0; b < int'($urandom_range(1, 3)); b++) stim.push_back(1'($urandom));
    end
    run_stream("random", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
